internal_bus_arbiter: RTL

Two-master arbiter for the internal 32-bit peripheral bus. It shares the bus between the uP interface controller (master 0) and an on-chip sequencer (master 1). A master holds the grant for a whole locked transaction, which may span several four-phase bus cycles. The arbiter also runs a watchdog that completes a hung bus cycle on the master's behalf, so a missing or dead subsystem cannot stall the bus.

---
 rtl/bus_pkg.sv | 15 +
 rtl/internal_bus_arbiter_if.sv | 38 +++
 rtl/bus_timeout_counter.sv | 27 ++
 rtl/internal_bus_arbiter.sv | 114 +++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the internal peripheral bus arbiter.
package bus_pkg;
  localparam int BUS_DATA_W          = 32;
  localparam int BUS_ADDR_W          = 8;
  localparam int DEFAULT_BUS_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GNT0   = 3'd1,
    S_GNT1   = 3'd2,
    S_ABORT0 = 3'd3,
    S_ABORT1 = 3'd4,
    S_REL    = 3'd5
  } arb_state_t;
endpackage

// File: rtl/internal_bus_arbiter_if.sv
// Signal bundle between the two bus masters, the subsystems and the arbiter.
interface internal_bus_arbiter_if;
  import bus_pkg::*;

  logic                  m0_req, m1_req;
  logic                  m0_grant, m1_grant;
  logic [BUS_DATA_W-1:0] m0_data_out, m1_data_out;
  logic [BUS_ADDR_W-1:0] m0_address, m1_address;
  logic                  m0_address_valid, m1_address_valid;
  logic                  m0_handshake_1, m1_handshake_1;
  logic                  m0_handshake_2, m1_handshake_2;
  logic                  m0_timeout, m1_timeout;
  logic [BUS_DATA_W-1:0] bus_data_out;
  logic [BUS_ADDR_W-1:0] bus_address;
  logic                  register_address_valid;
  logic                  bus_handshake_1;
  logic                  bus_handshake_2;

  // Masters and subsystems side.
  modport master (
    output m0_req, m1_req, m0_data_out, m1_data_out, m0_address, m1_address,
           m0_address_valid, m1_address_valid, m0_handshake_1, m1_handshake_1,
           bus_handshake_2,
    input  m0_grant, m1_grant, m0_handshake_2, m1_handshake_2, m0_timeout,
           m1_timeout, bus_data_out, bus_address, register_address_valid,
           bus_handshake_1
  );

  // Arbiter side.
  modport slave (
    input  m0_req, m1_req, m0_data_out, m1_data_out, m0_address, m1_address,
           m0_address_valid, m1_address_valid, m0_handshake_1, m1_handshake_1,
           bus_handshake_2,
    output m0_grant, m1_grant, m0_handshake_2, m1_handshake_2, m0_timeout,
           m1_timeout, bus_data_out, bus_address, register_address_valid,
           bus_handshake_1
  );
endinterface

// File: rtl/bus_timeout_counter.sv
// Watchdog down-counter: reloads to TIMEOUT_CYCLES-1, counts down to a sticky zero.
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic zero
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)             cnt_d = LOAD_VAL;
    else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= LOAD_VAL;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/internal_bus_arbiter.sv
// Two-master locked-transaction arbiter for the internal peripheral bus with a
// watchdog that completes a hung four-phase cycle on the owner's behalf.
module internal_bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_BUS_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  internal_bus_arbiter_if.slave  bus
);
  arb_state_t state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic       grant0_q, grant0_d, grant1_q, grant1_d;
  logic       tmo0_q, tmo0_d, tmo1_q, tmo1_d;

  logic owned, sel1, aborting, in_gnt;
  logic sel_req, sel_hs1, sel_av, hs2_ret;
  logic wd_load, wd_zero;

  assign sel1     = (state_q == S_GNT1) || (state_q == S_ABORT1);
  assign in_gnt   = (state_q == S_GNT0) || (state_q == S_GNT1);
  assign aborting = (state_q == S_ABORT0) || (state_q == S_ABORT1);
  assign owned    = in_gnt || aborting;

  assign sel_req = sel1 ? bus.m1_req           : bus.m0_req;
  assign sel_hs1 = sel1 ? bus.m1_handshake_1   : bus.m0_handshake_1;
  assign sel_av  = sel1 ? bus.m1_address_valid : bus.m0_address_valid;

  // Watchdog only runs while a granted cycle waits on the other side.
  assign wd_load = !in_gnt || (sel_hs1 == bus.bus_handshake_2);

  bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk   (clk),
    .reset (reset),
    .load  (wd_load),
    .zero  (wd_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      last_owner_q <= 1'b1;
      grant0_q     <= 1'b0;
      grant1_q     <= 1'b0;
      tmo0_q       <= 1'b0;
      tmo1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      grant0_q     <= grant0_d;
      grant1_q     <= grant1_d;
      tmo0_q       <= tmo0_d;
      tmo1_q       <= tmo1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.m0_req && bus.m1_req) state_d = last_owner_q ? S_GNT0 : S_GNT1;
        else if (bus.m0_req)          state_d = S_GNT0;
        else if (bus.m1_req)          state_d = S_GNT1;
        if (state_d != S_IDLE) last_owner_d = (state_d == S_GNT1);
      end
      S_GNT0, S_GNT1: begin
        // An expired watchdog wins even if the acknowledge lands this cycle.
        if (wd_zero)
          state_d = sel1 ? S_ABORT1 : S_ABORT0;
        else if (!sel_req && !sel_hs1 && !bus.bus_handshake_2)
          state_d = S_REL;
      end
      S_ABORT0, S_ABORT1: begin
        if (!sel_hs1 && !bus.bus_handshake_2) state_d = sel1 ? S_GNT1 : S_GNT0;
      end
      S_REL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant0_d = (state_d == S_GNT0) || (state_d == S_ABORT0);
    grant1_d = (state_d == S_GNT1) || (state_d == S_ABORT1);
    tmo0_d   = (state_q == S_GNT0) && (state_d == S_ABORT0);
    tmo1_d   = (state_q == S_GNT1) && (state_d == S_ABORT1);
  end

  // During an abort the strobe is hidden from the subsystems and echoed back.
  assign hs2_ret = aborting ? sel_hs1 : bus.bus_handshake_2;

  always_comb begin
    bus.bus_data_out           = '0;
    bus.bus_address            = '0;
    bus.register_address_valid = 1'b0;
    bus.bus_handshake_1        = 1'b0;
    bus.m0_handshake_2         = 1'b0;
    bus.m1_handshake_2         = 1'b0;
    if (owned) begin
      bus.bus_data_out           = sel1 ? bus.m1_data_out : bus.m0_data_out;
      bus.bus_address            = sel1 ? bus.m1_address  : bus.m0_address;
      bus.register_address_valid = sel_av  && !aborting;
      bus.bus_handshake_1        = sel_hs1 && !aborting;
      if (sel1) bus.m1_handshake_2 = hs2_ret;
      else      bus.m0_handshake_2 = hs2_ret;
    end
  end

  assign bus.m0_grant   = grant0_q;
  assign bus.m1_grant   = grant1_q;
  assign bus.m0_timeout = tmo0_q;
  assign bus.m1_timeout = tmo1_q;
endmodule
